ntt_mem_sched: RTL
==================

# ntt_mem_sched

Sequencer for one dual-port coefficient memory (`mem_dp`) in the NTT core.
- On `start`, it runs a full in-place Cooley-Tukey pass: log2(DEPTH) stages of DEPTH/2 butterflies each.
- Per butterfly it reads a coefficient pair on ports A/B, waits out the butterfly pipeline, then writes the results back to the same addresses and emits the matching twiddle index.
- While idle, it grants port A to a host (load/unload) requester.

## Interface
- `DEPTH`, 64: coefficient count; power of two, ≥ 4.
- `BFLY_LAT`, 4: butterfly pipeline latency in cycles; ≥ 1.
- `AW`, `CLOG2(DEPTH)`: address width (derived).
- `SW`, `CLOG2(AW)`: stage index width (derived; minimum 1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a transform; sampled only in IDLE.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final write.
- `stage` out SW: current stage index.
- `host_en`, `host_we` in 1 each: host access request / write.
- `host_addr` in AW: host address.
- `host_gnt` out 1: high while in IDLE and `start` is low.
- `ena`, `wea` out 1 each: memory port A enable / write.
- `addra` out AW: memory port A address.
- `enb`, `web` out 1 each: memory port B enable / write.
- `addrb` out AW: memory port B address.
- `tw_addr` out AW: twiddle ROM index for the current butterfly.
- `bf_valid` out 1: memory read data (`doa`/`dob`) is valid this cycle.
- `bf_wsel` out 1: external mux selects butterfly outputs onto `dia`/`dib`.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- Counters: stage `s` (0..AW-1), butterfly `k` (0..DEPTH/2-1), wait counter `w`.
- Address rule, with `h = DEPTH >> (s+1)`:
  - `addra = ((k >> log2 h) << (log2 h + 1)) | (k & (h-1))`
  - `addrb = addra + h`
  - `tw_addr = (1 << s) + (k >> (AW-1-s))`
  - All values fit in AW bits; no wrap.
- IDLE:
  - port A = host (`ena=host_en&host_gnt`, `wea=host_we&host_gnt`, `addra=host_addr`); `enb=web=0`.
  - `start` → READ, with `s=k=0`.
- READ (1 cycle): `ena=enb=1`, `wea=web=0`. → WAIT with `w=0`.
- WAIT (BFLY_LAT cycles):
  - ports disabled.
  - `bf_valid=1` in the first WAIT cycle only.
  - `w` increments; at `w=BFLY_LAT-1` → WRITE.
- WRITE (1 cycle): `ena=enb=wea=web=1`, `bf_wsel=1`, same addresses as the preceding READ.
  - If `k<DEPTH/2-1`: `k++`, → READ.
  - Else if `s<AW-1`: `k=0`, `s++`, → READ.
  - Else → DONE.
- DONE (1 cycle): `done=1`. → IDLE.
- `addra`/`addrb`/`tw_addr` are driven from `s`,`k` in every non-IDLE state.
- Ports are idle outside READ/WRITE.
- `start` while busy: ignored.
- `start` and `host_en` in the same IDLE cycle: start wins, `host_gnt=0`, host access dropped.
- Outputs are combinational from registered state/counters (Moore), except the host path, which is a combinational pass-through in IDLE.

## Timing
- Reset values:
  - state IDLE, `s=k=w=0`.
  - `busy=done=bf_valid=bf_wsel=0`.
  - `enb=web=0`; port A follows the host inputs.
  - `stage=0`.
- Reset mid-transform: immediate return to IDLE; no further memory writes. Memory contents are partially transformed (unspecified).
- Latency: `start` sampled in cycle 0 → first READ in cycle 1.
- Per butterfly: BFLY_LAT+2 cycles.
- Total: `done` in cycle 1 + AW·(DEPTH/2)·(BFLY_LAT+2).
- Read data valid one cycle after READ; butterfly output is expected exactly BFLY_LAT cycles after `bf_valid`, which is the WRITE cycle.
- Back-to-back transforms: `start` is accepted no earlier than the cycle after DONE.

## Structure
- Shared package `ntt_pkg`: state enum, `CLOG2`-based derived widths.
- Sub-module `ntt_addr_gen`: purely combinational `(s,k) → addra, addrb, tw_addr`; reusable by the multi-bank scheduler.

## Test plan
- DEPTH=8, BFLY_LAT=2, reset then `start` in cycle 0 → READ in cycle 1, `done` high only in cycle 49, `busy` high in cycles 1–49, IDLE in cycle 50.
- Same config, log READ cycles:
  - Stage 0 pairs (0,4),(1,5),(2,6),(3,7), tw 1,1,1,1.
  - Stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 2,2,3,3.
  - Stage 2 pairs (0,1),(2,3),(4,5),(6,7), tw 4,5,6,7.
  - Each WRITE uses the same pair exactly 3 cycles after its READ.
- Behavioral `mem_dp` and identity butterfly, memory preloaded with 0..7 → contents unchanged after `done`; `bf_valid` asserted 12 times, once per butterfly.
- Host writes addr 5 = 0x3C in IDLE → `ena=wea=1`, `addra=5`, `host_gnt=1`. Same request during busy → `host_gnt=0`, port A under scheduler control.
- `start` pulsed again in cycle 20 → ignored, `done` still in cycle 49. `start` and `host_en` together in IDLE → host dropped, transform starts.
- `rst_n` low in cycle 30 (mid-WAIT) → all outputs at reset values asynchronously; no `wea`/`web` afterwards; fresh `start` then completes normally.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT memory schedulers: state encoding and width helpers.
package ntt_pkg;

    // Scheduler states for one coefficient memory pass.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Same as clog2 but never returns less than 1, so the result is always a legal vector width.
    function automatic int clog2_min1(input int value);
        int result;
        result = clog2(value);
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational Cooley-Tukey address generator: (stage, butterfly) -> pair addresses and twiddle index.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int AW = 6,
    parameter int SW = 3
) (
    input  logic [SW-1:0] s,
    input  logic [AW-2:0] k,
    output logic [AW-1:0] addra,
    output logic [AW-1:0] addrb,
    output logic [AW-1:0] tw_addr
);

    localparam logic [SW-1:0] TOP_STAGE = SW'(AW - 1);

    logic [SW-1:0] lg_h;
    logic [AW-1:0] kk;
    logic [AW-1:0] mask;
    logic [AW-1:0] half;

    // The butterfly index splits into a group part (bits above log2 h) and an offset part; the
    // group part is shifted up by one to open a zero at bit log2 h, which is where the partner sits.
    always_comb begin
        lg_h    = TOP_STAGE - s;
        kk      = {1'b0, k};
        half    = AW'(1) << lg_h;
        mask    = half - AW'(1);
        addra   = ((kk & ~mask) << 1) | (kk & mask);
        addrb   = addra | half;
        tw_addr = (AW'(1) << s) + (kk >> lg_h);
    end

endmodule

// File: rtl/ntt_mem_sched.sv
// Sequencer driving one dual-port coefficient memory through a full in-place NTT pass.
module ntt_mem_sched
    import ntt_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int BFLY_LAT = 4,
    parameter int AW       = clog2(DEPTH),
    parameter int SW       = clog2_min1(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    output logic          host_gnt,
    output logic          ena,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic          enb,
    output logic          web,
    output logic [AW-1:0] addrb,
    output logic [AW-1:0] tw_addr,
    output logic          bf_valid,
    output logic          bf_wsel
);

    localparam int WW = clog2_min1(BFLY_LAT);
    localparam logic [WW-1:0] W_LAST = WW'(BFLY_LAT - 1);
    localparam logic [AW-2:0] K_LAST = {(AW - 1){1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(AW - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] s, s_nxt;
    logic [AW-2:0] k, k_nxt;
    logic [WW-1:0] w, w_nxt;

    logic [AW-1:0] gen_a;
    logic [AW-1:0] gen_b;

    ntt_addr_gen #(
        .AW (AW),
        .SW (SW)
    ) u_addr_gen (
        .s       (s),
        .k       (k),
        .addra   (gen_a),
        .addrb   (gen_b),
        .tw_addr (tw_addr)
    );

    // State and loop counters; reset drops any transform in flight straight back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            s     <= '0;
            k     <= '0;
            w     <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            k     <= k_nxt;
            w     <= w_nxt;
        end
    end

    // Next-state sequencing plus Moore outputs; in idle port A is a pass-through to the host.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        w_nxt     = w;
        busy      = 1'b1;
        done      = 1'b0;
        host_gnt  = 1'b0;
        ena       = 1'b0;
        wea       = 1'b0;
        enb       = 1'b0;
        web       = 1'b0;
        addra     = gen_a;
        addrb     = gen_b;
        bf_valid  = 1'b0;
        bf_wsel   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                host_gnt = !start;
                ena      = host_en && !start;
                wea      = host_we && !start;
                addra    = host_addr;
                if (start) begin
                    state_nxt = ST_READ;
                    s_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            ST_READ: begin
                ena       = 1'b1;
                enb       = 1'b1;
                w_nxt     = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                bf_valid = (w == '0);
                if (w == W_LAST) begin
                    state_nxt = ST_WRITE;
                end else begin
                    w_nxt = w + WW'(1);
                end
            end
            ST_WRITE: begin
                ena     = 1'b1;
                enb     = 1'b1;
                wea     = 1'b1;
                web     = 1'b1;
                bf_wsel = 1'b1;
                if (k != K_LAST) begin
                    k_nxt     = k + (AW - 1)'(1);
                    state_nxt = ST_READ;
                end else if (s != S_LAST) begin
                    k_nxt     = '0;
                    s_nxt     = s + SW'(1);
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stage = s;

endmodule
